// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers pixel coordinates, tracks lock and checksums frames.
// Define VGA_PROBE_EN to add the single-pixel colour probe (probe_x, probe_y, probe_color).
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
`ifdef VGA_PROBE_EN
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    output logic [11:0] probe_color,
`endif
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [23:0] frame_sum,
    output logic        sum_valid
);

    localparam int          LCW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]  H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [LCW-1:0]  lock_cnt, lock_cnt_nxt;
    logic [9:0]      hcnt, lcnt, hcnt_nxt, lcnt_nxt;
    logic            hs_prev, vs_prev;
    logic            hs_fall, vs_fall, h_bad, v_bad, err;
    logic            act_nxt;
    logic [9:0]      x_nxt;
    logic [8:0]      y_nxt;
    logic [11:0]     rgb;
    logic [23:0]     acc, acc_sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rgb      = {VGA_R, VGA_G, VGA_B};
        hs_fall  = hs_prev & ~hSync;
        vs_fall  = vs_prev & ~vSync;
        h_bad    = 1'b0;
        v_bad    = 1'b0;
        hcnt_nxt = hcnt;
        lcnt_nxt = lcnt;

        // Line/frame length checks use the pre-update counters.
        if (hs_fall && state != SEARCH && ({1'b0, hcnt} + 11'd1) != H_TOTAL_W)
            h_bad = 1'b1;
        if (vs_fall && state != SEARCH && ({1'b0, lcnt} + 11'd1) != V_TOTAL_W)
            v_bad = 1'b1;

        if (hs_fall)
            hcnt_nxt = '0;
        else if (hcnt != 10'h3FF)
            hcnt_nxt = hcnt + 10'd1;

        if (vs_fall)
            lcnt_nxt = '0;
        else if (hs_fall && lcnt != 10'h3FF)
            lcnt_nxt = lcnt + 10'd1;

        err     = h_bad | v_bad;
        act_nxt = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                  (lcnt_nxt >= V_START) && (lcnt_nxt < V_END);
        x_nxt   = act_nxt ? (hcnt_nxt - H_START) : '0;
        y_nxt   = act_nxt ? 9'(lcnt_nxt - V_START) : '0;
        acc_sum = acc + (act_nxt ? {12'd0, rgb} : 24'd0);
    end

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (pix_en) begin
            unique case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state_nxt    = ACQUIRE;
                        lock_cnt_nxt = '0;
                    end
                end
                ACQUIRE: begin
                    if (err) begin
                        state_nxt    = SEARCH;
                        lock_cnt_nxt = '0;
                    end else if (vs_fall) begin
                        lock_cnt_nxt = lock_cnt + LCW'(1);
                        if (lock_cnt + LCW'(1) == LCW'(LOCK_FRAMES))
                            state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (err) begin
                        state_nxt    = SEARCH;
                        lock_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = SEARCH;
                    lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Lock drops on the same edge that registers the error pulse.
    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            lock_cnt    <= '0;
            hcnt        <= '0;
            lcnt        <= '0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            acc         <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_sum   <= '0;
            sum_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all registered state.
            state       <= state_nxt;
            lock_cnt    <= lock_cnt_nxt;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            sum_valid   <= 1'b0;
            if (pix_en) begin
                hs_prev     <= hSync;
                vs_prev     <= vSync;
                hcnt        <= hcnt_nxt;
                lcnt        <= lcnt_nxt;
                active      <= act_nxt;
                x           <= x_nxt;
                y           <= y_nxt;
                h_err       <= h_bad;
                v_err       <= v_bad;
                frame_start <= vs_fall;
                if (vs_fall) begin
                    frame_sum <= acc_sum;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

`ifdef VGA_PROBE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            probe_color <= '0;
        else if (pix_en && act_nxt && x_nxt == probe_x && y_nxt == probe_y)
            probe_color <= rgb;
    end
`endif

endmodule
